// File: rtl/imm_gen_if.sv
// Fetch-to-decode handshake bundle for imm_gen_pipe: instruction push side and
// decoded-record pop side. master = testbench/fetch+consumer, slave = the pipe.
interface imm_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_word;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      fmt;
  logic            err;
  logic [7:0]      err_cnt;

  modport master (
    output in_valid, instr_word, out_ready,
    input  in_ready, out_valid, imm, rd, rs1, rs2, fmt, err, err_cnt
  );

  modport slave (
    input  in_valid, instr_word, out_ready,
    output in_ready, out_valid, imm, rd, rs1, rs2, fmt, err, err_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator / field extractor behind a 2-entry valid/ready buffer.
// Optional IMM_GEN_ERR_EN: flag illegal opcodes (fmt=7, err=1) and count them.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  imm_gen_if.slave bus
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned FMT_W  = 3;
  localparam int unsigned ERRC_W = 8;

  localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S   = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U   = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J   = 3'd5;
  localparam logic [FMT_W-1:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [FMT_W-1:0] fmt;
    logic             err;
  } dec_t;

  // Buffer occupancy; encodings equal the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  dec_t             r_head;
  dec_t             r_tail;
  dec_t             w_dec;
  logic [FMT_W-1:0] w_kind;
  logic [31:0]      w_imm32;
  logic [31:0]      w_instr;
  logic             w_push;
  logic             w_pop;
  logic             w_load_head;
  logic             w_shift_tail;
  logic             w_load_tail;

  assign w_instr = bus.instr_word;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    w_kind  = FMT_ILL;
    w_imm32 = '0;
    w_dec   = '0;
    case (w_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111: w_kind = FMT_I;
      7'b0011011:             w_kind = (XLEN == 64) ? FMT_I : FMT_ILL;
      7'b0100011:             w_kind = FMT_S;
      7'b1100011:             w_kind = FMT_B;
      7'b0110111, 7'b0010111: w_kind = FMT_U;
      7'b1101111:             w_kind = FMT_J;
      7'b0110011:             w_kind = FMT_R;
      7'b0111011:             w_kind = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:                w_kind = FMT_ILL;
    endcase
`ifndef IMM_GEN_ERR_EN
    if (w_kind == FMT_ILL) w_kind = FMT_R;
`endif
    w_dec.fmt = w_kind;
    case (w_kind)
      FMT_R: begin
        w_dec.rd  = w_instr[11:7];
        w_dec.rs1 = w_instr[19:15];
        w_dec.rs2 = w_instr[24:20];
      end
      FMT_I: begin
        w_imm32   = 32'($signed(w_instr[31:20]));
        w_dec.rd  = w_instr[11:7];
        w_dec.rs1 = w_instr[19:15];
      end
      FMT_S: begin
        w_imm32   = 32'($signed({w_instr[31:25], w_instr[11:7]}));
        w_dec.rs1 = w_instr[19:15];
        w_dec.rs2 = w_instr[24:20];
      end
      FMT_B: begin
        w_imm32   = 32'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                 w_instr[11:8], 1'b0}));
        w_dec.rs1 = w_instr[19:15];
        w_dec.rs2 = w_instr[24:20];
      end
      FMT_U: begin
        w_imm32  = {w_instr[31:12], 12'b0};
        w_dec.rd = w_instr[11:7];
      end
      FMT_J: begin
        w_imm32  = 32'($signed({w_instr[31], w_instr[19:12], w_instr[20],
                                w_instr[30:21], 1'b0}));
        w_dec.rd = w_instr[11:7];
      end
      default: begin
`ifdef IMM_GEN_ERR_EN
        w_dec.err = 1'b1;
`endif
      end
    endcase
    w_dec.imm = XLEN'($signed(w_imm32));
  end

  assign bus.in_ready  = (r_state != ST_FULL) & rst_n;
  assign bus.out_valid = (r_state != ST_EMPTY);

  // flush wins over both handshakes, so a same-cycle push is dropped.
  assign w_push = bus.in_valid & bus.in_ready & ~flush;
  assign w_pop  = bus.out_valid & bus.out_ready & ~flush;

  // Occupancy next-state and data-movement strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_head  = 1'b0;
    w_shift_tail = 1'b0;
    w_load_tail  = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_load_head = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_load_head = 1'b1;
          end else if (w_push) begin
            w_load_tail = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_shift_tail = 1'b1;
            w_state_nxt  = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Head register drives the outputs directly; tail only holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_load_head) begin
        r_head <= w_dec;
      end else if (w_shift_tail) begin
        r_head <= r_tail;
      end
      if (w_load_tail) begin
        r_tail <= w_dec;
      end
    end
  end

  assign bus.imm = r_head.imm;
  assign bus.rd  = r_head.rd;
  assign bus.rs1 = r_head.rs1;
  assign bus.rs2 = r_head.rs2;
  assign bus.fmt = r_head.fmt;
  assign bus.err = r_head.err;

`ifdef IMM_GEN_ERR_EN
  logic [ERRC_W-1:0] r_err_cnt;

  // Saturating count of accepted illegal entries; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_push && w_dec.err && (r_err_cnt != {ERRC_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERRC_W'(1);
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = ERRC_W'(0);
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vector tables on XLEN=32 and XLEN=64
// instances, plus backpressure, flush, illegal-opcode, saturation and reset sequences.
module tb_imm_gen_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(32)) bus32();
  imm_gen_if #(.XLEN(64)) bus64();

  imm_gen_pipe #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));
  imm_gen_pipe #(.XLEN(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64));

`ifdef IMM_GEN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fmt;
    logic        err;
  } vec_t;

  vec_t tbl32[$];
  vec_t tbl64[$];

  function automatic vec_t mk(input logic [31:0] instr, input logic [63:0] imm,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] fmt);
    vec_t v;
    v.instr = instr; v.imm = imm; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.fmt = fmt; v.err = 1'b0;
    return v;
  endfunction

  // Illegal opcode: flagged record when the error option is built, else an R-format decode.
  function automatic vec_t mk_ill(input logic [31:0] instr, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2);
    vec_t v;
    v.instr = instr; v.imm = '0;
    v.rd  = ERR_EN ? 5'd0 : rd;
    v.rs1 = ERR_EN ? 5'd0 : rs1;
    v.rs2 = ERR_EN ? 5'd0 : rs2;
    v.fmt = ERR_EN ? 3'd7 : 3'd0;
    v.err = ERR_EN;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string tag, input vec_t v);
    logic [31:0] e_imm;
    e_imm = v.imm[31:0];
    chk({tag, ".valid"}, 64'(bus32.out_valid), 64'd1);
    chk({tag, ".imm"},   64'(bus32.imm), 64'(e_imm));
    chk({tag, ".rd"},    64'(bus32.rd),  64'(v.rd));
    chk({tag, ".rs1"},   64'(bus32.rs1), 64'(v.rs1));
    chk({tag, ".rs2"},   64'(bus32.rs2), 64'(v.rs2));
    chk({tag, ".fmt"},   64'(bus32.fmt), 64'(v.fmt));
    chk({tag, ".err"},   64'(bus32.err), 64'(v.err));
  endtask

  task automatic chk64(input string tag, input vec_t v);
    chk({tag, ".valid"}, 64'(bus64.out_valid), 64'd1);
    chk({tag, ".imm"},   bus64.imm,          v.imm);
    chk({tag, ".rd"},    64'(bus64.rd),  64'(v.rd));
    chk({tag, ".rs1"},   64'(bus64.rs1), 64'(v.rs1));
    chk({tag, ".rs2"},   64'(bus64.rs2), 64'(v.rs2));
    chk({tag, ".fmt"},   64'(bus64.fmt), 64'(v.fmt));
    chk({tag, ".err"},   64'(bus64.err), 64'(v.err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus32.in_valid = 1'b0; bus64.in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t va, vb, vc, vill;

  initial begin
    bus32.in_valid = 1'b0; bus32.instr_word = '0; bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.instr_word = '0; bus64.out_ready = 1'b1;

    tbl32.push_back(mk(32'h001000EF, 64'h0000_0000_0000_0800, 5'd1, 5'd0,  5'd0, 3'd5));
    tbl32.push_back(mk(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0,  5'd0, 3'd3));
    tbl32.push_back(mk(32'hFFF50293, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 5'd10, 5'd0, 3'd1));
    tbl32.push_back(mk(32'h00612423, 64'h0000_0000_0000_0008, 5'd0, 5'd2,  5'd6, 3'd2));
    tbl32.push_back(mk(32'hFE11AC23, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 5'd3,  5'd1, 3'd2));
    tbl32.push_back(mk(32'h005201B3, 64'h0,                   5'd3, 5'd4,  5'd5, 3'd0));
    tbl32.push_back(mk(32'h800002B7, 64'hFFFF_FFFF_8000_0000, 5'd5, 5'd0,  5'd0, 3'd4));
    tbl32.push_back(mk(32'h12345397, 64'h0000_0000_1234_5000, 5'd7, 5'd0,  5'd0, 3'd4));
    tbl32.push_back(mk(32'hFFFFF06F, 64'hFFFF_FFFF_FFFF_FFFE, 5'd0, 5'd0,  5'd0, 3'd5));
    tbl32.push_back(mk(32'h0FF0000F, 64'h0000_0000_0000_00FF, 5'd0, 5'd0,  5'd0, 3'd1));
    tbl32.push_back(mk_ill(32'hFFFFFFFF, 5'd31, 5'd31, 5'd31));
    tbl32.push_back(mk_ill(32'h0011B03B, 5'd0,  5'd3,  5'd1));
    tbl32.push_back(mk_ill(32'hFFF2829B, 5'd5,  5'd5,  5'd31));

    tbl64.push_back(mk(32'h800002B7, 64'hFFFF_FFFF_8000_0000, 5'd5, 5'd0, 5'd0, 3'd4));
    tbl64.push_back(mk(32'hFFF2829B, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 5'd5, 5'd0, 3'd1));
    tbl64.push_back(mk(32'h0011B03B, 64'h0,                   5'd0, 5'd3, 5'd1, 3'd0));
    tbl64.push_back(mk(32'h001000EF, 64'h0000_0000_0000_0800, 5'd1, 5'd0, 5'd0, 3'd5));
    tbl64.push_back(mk(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0, 5'd0, 3'd3));
    tbl64.push_back(mk(32'hFE11AC23, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 5'd3, 5'd1, 3'd2));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.in_ready",  64'(bus32.in_ready),  64'd0);
    chk("rst.out_valid", 64'(bus32.out_valid), 64'd0);
    chk("rst.imm",       64'(bus32.imm),       64'd0);
    chk("rst.rd",        64'(bus32.rd),        64'd0);
    chk("rst.fmt",       64'(bus32.fmt),       64'd0);
    chk("rst.err",       64'(bus32.err),       64'd0);
    chk("rst.err_cnt",   64'(bus32.err_cnt),   64'd0);
    chk("rst.imm64",     bus64.imm,            64'd0);
    rst_n = 1'b1;
    #1 chk("rst.in_ready_after", 64'(bus32.in_ready), 64'd1);

    // First push in the first clock after reset release, then the 32-bit table
    for (int i = 0; i < tbl32.size(); i++) begin
      if (i != 0) @(negedge clk);
      bus32.in_valid = 1'b1; bus32.instr_word = tbl32[i].instr;
      @(negedge clk);
      bus32.in_valid = 1'b0;
      chk32($sformatf("x32[%0d]", i), tbl32[i]);
    end

    for (int i = 0; i < tbl64.size(); i++) begin
      @(negedge clk);
      bus64.in_valid = 1'b1; bus64.instr_word = tbl64[i].instr;
      @(negedge clk);
      bus64.in_valid = 1'b0;
      chk64($sformatf("x64[%0d]", i), tbl64[i]);
    end

    // Backpressure: A, B fill the buffer, C is held, then all drain in order
    va = tbl32[0]; vb = tbl32[1]; vc = tbl32[2];
    do_reset();
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.instr_word = va.instr;
    @(negedge clk);
    chk("bp.ready_after_a", 64'(bus32.in_ready), 64'd1);
    chk32("bp.head_a1", va);
    bus32.instr_word = vb.instr;
    @(negedge clk);
    chk("bp.ready_after_b", 64'(bus32.in_ready), 64'd0);
    chk32("bp.head_a2", va);
    bus32.instr_word = vc.instr;
    @(negedge clk);
    chk("bp.ready_stall", 64'(bus32.in_ready), 64'd0);
    chk32("bp.head_a3", va);
    bus32.out_ready = 1'b1;
    @(negedge clk);
    chk32("bp.drain_b", vb);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    chk32("bp.drain_c", vc);
    @(negedge clk);
    chk("bp.empty", 64'(bus32.out_valid), 64'd0);

    // Flush at count 2 with a push request in the same cycle
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.instr_word = va.instr;
    @(negedge clk);
    bus32.instr_word = vb.instr;
    @(negedge clk);
    chk("fl.full", 64'(bus32.in_ready), 64'd0);
    flush = 1'b1; bus32.instr_word = vc.instr;
    @(negedge clk);
    flush = 1'b0; bus32.in_valid = 1'b0;
    chk("fl.valid", 64'(bus32.out_valid), 64'd0);
    chk("fl.ready", 64'(bus32.in_ready),  64'd1);
    @(negedge clk);
    chk("fl.stays_empty", 64'(bus32.out_valid), 64'd0);

    // Flush at count 1 drops an accepted-looking push; next push becomes head
    bus32.in_valid = 1'b1; bus32.instr_word = va.instr;
    @(negedge clk);
    flush = 1'b1; bus32.instr_word = vc.instr;
    @(negedge clk);
    flush = 1'b0; bus32.instr_word = vb.instr;
    chk("fl1.valid", 64'(bus32.out_valid), 64'd0);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    chk32("fl1.head_b", vb);
    bus32.out_ready = 1'b1;
    @(negedge clk);
    chk("fl1.empty", 64'(bus32.out_valid), 64'd0);

    // Illegal opcode pushed twice, then reset mid-stream
    vill = mk_ill(32'h0000007F, 5'd0, 5'd0, 5'd0);
    do_reset();
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.instr_word = vill.instr;
    @(negedge clk);
    chk32("ill.first", vill);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    chk("ill.err_cnt2", 64'(bus32.err_cnt), ERR_EN ? 64'd2 : 64'd0);
    bus32.out_ready = 1'b1;
    @(negedge clk);
    chk32("ill.second", vill);
    bus32.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ill.rst_valid",   64'(bus32.out_valid), 64'd0);
    chk("ill.rst_err_cnt", 64'(bus32.err_cnt),   64'd0);
    chk("ill.rst_ready",   64'(bus32.in_ready),  64'd0);
    chk("ill.rst_fmt",     64'(bus32.fmt),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // err_cnt saturation: 260 illegal pushes at full throughput
    bus32.out_ready = 1'b1;
    bus32.in_valid = 1'b1; bus32.instr_word = vill.instr;
    repeat (254) @(negedge clk);
    chk("sat.254", 64'(bus32.err_cnt), ERR_EN ? 64'd254 : 64'd0);
    repeat (6) @(negedge clk);
    bus32.in_valid = 1'b0;
    chk("sat.255", 64'(bus32.err_cnt), ERR_EN ? 64'd255 : 64'd0);
    chk("sat.valid", 64'(bus32.out_valid), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("sat.flush_keeps", 64'(bus32.err_cnt), ERR_EN ? 64'd255 : 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised RISC-V immediate generator and field extractor. It decodes all base formats (R/I/S/B/U/J), sign-extends the immediate to XLEN, and extracts rd/rs1/rs2. A 2-entry valid/ready buffer sits between the instruction-fetch stage and the decode/execute stage, giving full throughput under backpressure. It supersedes the per-format J-type extractor.

## Interface
- XLEN, 32: immediate width; legal values 32 or 64.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  instr_word is valid.
- in_ready  out  1  buffer can accept this cycle.
- instr_word  in  32  raw instruction.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the entry.
- imm  out  XLEN  sign-extended immediate.
- rd, rs1, rs2  out  5 each  register fields; 0 where the format has no such field.
- fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- err  out  1  illegal-opcode flag (see Configuration).
- err_cnt  out  8  saturating count of illegal opcodes accepted.

## Operation
- Decode is combinational on instr_word. The decoded record {imm, rd, rs1, rs2, fmt, err} is written into the buffer on a push.
- Opcode[6:0] selects the format:
  - I: 0010011, 0000011, 1100111, 1110011, 0001111; plus 0011011 only when XLEN=64.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - R: 0110011; plus 0111011 only when XLEN=64.
  - Any other opcode is illegal.
- Immediates, each sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R: 0.
- Register fields:
  - rd = instr[11:7] for R/I/U/J.
  - rs1 = instr[19:15] for R/I/S/B.
  - rs2 = instr[24:20] for R/S/B.
  - Every unused field is 0.
- Buffer: 2-entry FIFO with a 2-bit count.
  - push = in_valid & in_ready. pop = out_valid & out_ready.
  - in_ready = (count < 2) & rst_n. out_valid = (count != 0).
  - Order is strictly preserved.
- Simultaneous push and pop at count 1: count stays 1, and the new entry becomes head on the next cycle.
- Push at count 2 is impossible because in_ready is 0.
- Outputs reflect the head entry. They must not change while out_valid=1 and out_ready=0.
- flush clears the count and drops the same-cycle push. It takes priority over push and pop. err_cnt is not cleared.
- Reset (mid-operation included) clears count, head and tail pointers, err_cnt, and all outputs.
- Reset values: out_valid=0, imm=0, rd=rs1=rs2=0, fmt=0, err=0, err_cnt=0, in_ready=0.

## Timing
- Latency: an instruction accepted in cycle N is visible on the outputs in cycle N+1 if the buffer was empty.
- Throughput: 1 instruction per cycle when out_ready is held at 1.
- in_ready depends only on registered count and rst_n, with no combinational path from out_ready.
- First push is possible in the first clock after rst_n deasserts.

## Configuration
- IMM_GEN_ERR_EN defined:
  - An illegal opcode gives fmt=7, err=1, imm=0, rd=rs1=rs2=0.
  - err_cnt increments on each push of an illegal entry and saturates at 255.
- IMM_GEN_ERR_EN undefined:
  - Illegal opcodes decode as R (fmt=0, imm=0, rd/rs1/rs2 from their fields).
  - err and err_cnt are tied to 0.
  - The counter logic is not synthesised.

## Test plan
- XLEN=32, push 0x001000EF (jal x1, +2048), out_ready=1: next cycle out_valid=1, imm=0x00000800, rd=1, rs1=0, rs2=0, fmt=5.
- Push 0xFE000EE3 (beq x0, x0, -4): imm=0xFFFFFFFC, fmt=3, rd=0, rs1=0, rs2=0.
- XLEN=64, push 0x800002B7 (lui x5, 0x80000): imm=0xFFFFFFFF80000000, rd=5, fmt=4.
- out_ready=0, push A, B, C back-to-back:
  - A and B are accepted; in_ready=0 after B; C is held by the source.
  - Outputs stay at A while stalled.
  - Raise out_ready: A, B, C drain in order, one per cycle.
- Count=2 with flush=1 and in_valid=1 in the same cycle: next cycle out_valid=0, in_ready=1, and the flushed push never appears.
- IMM_GEN_ERR_EN defined, push 0x0000007F twice: both entries show fmt=7, err=1; err_cnt reaches 2. Asserting rst_n=0 mid-stream clears out_valid and err_cnt immediately.
